// File: rtl/hamming_secded_reg.sv
// SECDED-protected storage register: Hamming-encodes on write, decodes and corrects on read.
// Optional FAULT_INJECTION_EN macro adds a codeword XOR port for error injection.
module hamming_secded_reg #(
  parameter int DATA_WIDTH = 26,
  parameter bit SCRUB_EN   = 1'b1,
  parameter int CNT_WIDTH  = 8,
  localparam int N_CHECKB  = (DATA_WIDTH <= 1)   ? 2 :
                             (DATA_WIDTH <= 4)   ? 3 :
                             (DATA_WIDTH <= 11)  ? 4 :
                             (DATA_WIDTH <= 26)  ? 5 :
                             (DATA_WIDTH <= 57)  ? 6 :
                             (DATA_WIDTH <= 120) ? 7 : 8,
  localparam int CW_WIDTH  = DATA_WIDTH + N_CHECKB + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  re_i,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  sec_o,
  output logic                  ded_o,
  output logic                  err_sticky_o,
  output logic [CNT_WIDTH-1:0]  sec_cnt_o,
  output logic [CNT_WIDTH-1:0]  ded_cnt_o,
  input  logic                  clr_cnt_i
`ifdef FAULT_INJECTION_EN
  ,
  input  logic                  inj_en_i,
  input  logic [CW_WIDTH-1:0]   inj_mask_i
`endif
);

  // Data occupies every non-power-of-two position from 3 upward, LSB first.
  function automatic logic [CW_WIDTH-1:0] encode(input logic [DATA_WIDTH-1:0] d);
    logic [CW_WIDTH-1:0] cw;
    int di;
    cw = '0;
    di = 0;
    for (int pos = 1; pos < CW_WIDTH; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos] = d[di];
        di++;
      end
    end
    for (int k = 0; k < N_CHECKB; k++) begin
      for (int pos = 1; pos < CW_WIDTH; pos++) begin
        if (((pos >> k) & 1) == 1 && (pos & (pos - 1)) != 0)
          cw[1 << k] = cw[1 << k] ^ cw[pos];
      end
    end
    cw[0] = ^cw[CW_WIDTH-1:1];
    return cw;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] extract(input logic [CW_WIDTH-1:0] cw);
    logic [DATA_WIDTH-1:0] d;
    int di;
    d  = '0;
    di = 0;
    for (int pos = 1; pos < CW_WIDTH; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d[di] = cw[pos];
        di++;
      end
    end
    return d;
  endfunction

  function automatic logic [N_CHECKB-1:0] syndrome(input logic [CW_WIDTH-1:0] cw);
    logic [N_CHECKB-1:0] s;
    s = '0;
    for (int pos = 1; pos < CW_WIDTH; pos++) begin
      if (cw[pos])
        s = s ^ N_CHECKB'(pos);
    end
    return s;
  endfunction

  logic [CW_WIDTH-1:0]   cw_reg;
  logic                  rvalid_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic                  sec_reg;
  logic                  ded_reg;
  logic                  sticky_reg;
  logic [CNT_WIDTH-1:0]  sec_cnt_reg;
  logic [CNT_WIDTH-1:0]  ded_cnt_reg;

  logic [N_CHECKB-1:0]   syn;
  logic                  par;
  logic                  dec_sec;
  logic                  dec_ded;
  logic [CW_WIDTH-1:0]   flip;
  logic [CW_WIDTH-1:0]   cw_fixed;
  logic [DATA_WIDTH-1:0] dec_data;

  assign syn     = syndrome(cw_reg);
  assign par     = ^cw_reg;
  // Odd parity with an in-range syndrome is a single flip; s=0 points at the parity bit.
  assign dec_sec = par && (int'(syn) < CW_WIDTH);
  assign dec_ded = (!par && (syn != '0)) || (par && (int'(syn) >= CW_WIDTH));

  genvar gi;
  generate
    for (gi = 0; gi < CW_WIDTH; gi++) begin : g_flip
      assign flip[gi] = dec_sec && (int'(syn) == gi);
    end
  endgenerate

  // flip is zero on DED, so the same extractor yields the raw data there.
  assign cw_fixed = cw_reg ^ flip;
  assign dec_data = extract(cw_fixed);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cw_reg      <= '0;
      rvalid_reg  <= 1'b0;
      data_reg    <= '0;
      sec_reg     <= 1'b0;
      ded_reg     <= 1'b0;
      sticky_reg  <= 1'b0;
      sec_cnt_reg <= '0;
      ded_cnt_reg <= '0;
    end else begin
      rvalid_reg <= re_i;
      if (re_i) begin
        data_reg <= dec_data;
        sec_reg  <= dec_sec;
        ded_reg  <= dec_ded;
      end

      if (we_i)
        cw_reg <= encode(data_i);
      else if (SCRUB_EN && re_i && dec_sec)
        cw_reg <= cw_fixed;
`ifdef FAULT_INJECTION_EN
      else if (inj_en_i)
        cw_reg <= cw_reg ^ inj_mask_i;
`endif

      if (clr_cnt_i) begin
        sec_cnt_reg <= '0;
        ded_cnt_reg <= '0;
        sticky_reg  <= 1'b0;
      end else if (re_i) begin
        if (dec_sec && (sec_cnt_reg != '1))
          sec_cnt_reg <= sec_cnt_reg + 1'b1;
        if (dec_ded && (ded_cnt_reg != '1))
          ded_cnt_reg <= ded_cnt_reg + 1'b1;
        if (dec_ded)
          sticky_reg <= 1'b1;
      end
    end
  end

  assign rvalid_o     = rvalid_reg;
  assign data_o       = data_reg;
  assign sec_o        = sec_reg;
  assign ded_o        = ded_reg;
  assign err_sticky_o = sticky_reg;
  assign sec_cnt_o    = sec_cnt_reg;
  assign ded_cnt_o    = ded_cnt_reg;

endmodule

// File: tb/tb_hamming_secded_reg.sv
// Directed bench for hamming_secded_reg: default instance plus a 2-bit-counter, no-scrub instance.
// Storage faults are planted by briefly forcing the stored codeword.
module tb_hamming_secded_reg;

  localparam logic [31:0] CW_REF = 32'hAAF3_BDEB;  // encode(26'h2AB_CDEF)

  logic        clk;
  logic        rst;
  logic        we, re, clr;
  logic [25:0] din;
  logic        rvalid, sec, ded, sticky;
  logic [25:0] dout;
  logic [7:0]  sec_cnt, ded_cnt;

  logic        we2, re2, clr2;
  logic [25:0] din2;
  logic        rvalid2, sec2, ded2, sticky2;
  logic [25:0] dout2;
  logic [1:0]  sec_cnt2, ded_cnt2;

  logic [31:0] forced_cw;
  int          n_checks;
  int          n_fail;

  hamming_secded_reg dut (
    .clk_i(clk), .rst_i(rst), .we_i(we), .data_i(din), .re_i(re),
    .rvalid_o(rvalid), .data_o(dout), .sec_o(sec), .ded_o(ded),
    .err_sticky_o(sticky), .sec_cnt_o(sec_cnt), .ded_cnt_o(ded_cnt),
    .clr_cnt_i(clr)
`ifdef FAULT_INJECTION_EN
    , .inj_en_i(1'b0), .inj_mask_i(32'h0)
`endif
  );

  hamming_secded_reg #(.DATA_WIDTH(26), .SCRUB_EN(1'b0), .CNT_WIDTH(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .we_i(we2), .data_i(din2), .re_i(re2),
    .rvalid_o(rvalid2), .data_o(dout2), .sec_o(sec2), .ded_o(ded2),
    .err_sticky_o(sticky2), .sec_cnt_o(sec_cnt2), .ded_cnt_o(ded_cnt2),
    .clr_cnt_i(clr2)
`ifdef FAULT_INJECTION_EN
    , .inj_en_i(1'b0), .inj_mask_i(32'h0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd1();
    re = 1'b1;
    tick();
    re = 1'b0;
  endtask

  task automatic rd2();
    re2 = 1'b1;
    tick();
    re2 = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    we = 1'b0; re = 1'b1; clr = 1'b0; din = '0;
    we2 = 1'b0; re2 = 1'b0; clr2 = 1'b0; din2 = '0;
    forced_cw = '0;
    tick();
    tick();
    check("rst_no_rvalid", rvalid, 1'b0);
    rst = 1'b0;
    re  = 1'b0;
    check("rst_data", dout, 26'h0);
    check("rst_flags", {sec, ded, sticky}, 3'b000);
    check("rst_cnts", {sec_cnt, ded_cnt}, 16'h0);

    rd1();
    check("rd0_rvalid", rvalid, 1'b1);
    check("rd0_data", dout, 26'h0);
    check("rd0_flags", {sec, ded}, 2'b00);
    tick();
    check("rvalid_drop", rvalid, 1'b0);

    din = 26'h2AB_CDEF; we = 1'b1; tick(); we = 1'b0;
    check("enc_layout", dut.cw_reg, CW_REF);
    rd1();
    check("clean_data", dout, 26'h2AB_CDEF);
    check("clean_flags", {sec, ded}, 2'b00);

    // single flip at position 13 (data bit 8)
    forced_cw = CW_REF ^ 32'h0000_2000;
    force dut.cw_reg = forced_cw;
    #1 release dut.cw_reg;
    rd1();
    check("sec13_data", dout, 26'h2AB_CDEF);
    check("sec13_flags", {sec, ded}, 2'b10);
    check("sec13_cnt", sec_cnt, 8'd1);
    check("scrub_cw", dut.cw_reg, CW_REF);
    rd1();
    check("after_scrub_flags", {sec, ded}, 2'b00);
    check("after_scrub_data", dout, 26'h2AB_CDEF);
    check("after_scrub_cnt", sec_cnt, 8'd1);

    // flip of the overall parity bit is still a SEC
    forced_cw = CW_REF ^ 32'h0000_0001;
    force dut.cw_reg = forced_cw;
    #1 release dut.cw_reg;
    rd1();
    check("sec0_flags", {sec, ded}, 2'b10);
    check("sec0_data", dout, 26'h2AB_CDEF);
    check("sec0_cnt", sec_cnt, 8'd2);

    // double flip at 5 and 9: raw data has bits 1 and 4 inverted
    forced_cw = CW_REF ^ 32'h0000_0220;
    force dut.cw_reg = forced_cw;
    #1 release dut.cw_reg;
    rd1();
    check("ded_flags", {sec, ded}, 2'b01);
    check("ded_data", dout, 26'h2AB_CDFD);
    check("ded_sticky", sticky, 1'b1);
    check("ded_cnt1", ded_cnt, 8'd1);
    rd1();
    check("ded_again", {sec, ded}, 2'b01);
    check("ded_cnt2", ded_cnt, 8'd2);
    check("sec_cnt_kept", sec_cnt, 8'd2);

    clr = 1'b1; tick(); clr = 1'b0;
    check("clr_cnts", {sec_cnt, ded_cnt}, 16'h0);
    check("clr_sticky", sticky, 1'b0);

    din = 26'h3FF_FFFF; we = 1'b1; tick(); we = 1'b0;
    rd1();
    check("ones_data", dout, 26'h3FF_FFFF);
    din = 26'h1; we = 1'b1; re = 1'b1; tick(); we = 1'b0; re = 1'b0;
    check("rw_old_data", dout, 26'h3FF_FFFF);
    check("rw_rvalid", rvalid, 1'b1);
    rd1();
    check("rw_new_data", dout, 26'h1);
    check("rw_new_flags", {sec, ded}, 2'b00);

    re = 1'b1; rst = 1'b1; tick(); re = 1'b0; rst = 1'b0;
    tick();
    check("rst_midread_rvalid", rvalid, 1'b0);
    check("rst_midread_data", dout, 26'h0);

    // saturation on the 2-bit, non-scrubbing instance
    din2 = 26'h2AB_CDEF; we2 = 1'b1; tick(); we2 = 1'b0;
    forced_cw = CW_REF ^ 32'h0000_2000;
    force dut2.cw_reg = forced_cw;
    #1 release dut2.cw_reg;
    for (int n = 1; n <= 5; n++) begin
      rd2();
      check($sformatf("sat_rd%0d_flags", n), {sec2, ded2}, 2'b10);
      check($sformatf("sat_rd%0d_cnt", n), sec_cnt2, (n > 3) ? 2'd3 : 2'(n));
    end
    check("sat_data", dout2, 26'h2AB_CDEF);
    clr2 = 1'b1; re2 = 1'b1; tick(); clr2 = 1'b0; re2 = 1'b0;
    check("clr_vs_inc_cnt", sec_cnt2, 2'd0);
    check("clr_vs_inc_sec", sec2, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
